// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: per-slot entry state and ring-age helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package rob_pkg;

  localparam int ROB_STATE_W = 2;

  typedef enum logic [ROB_STATE_W-1:0] {
    ROB_IDLE = 2'd0,
    ROB_BUSY = 2'd1,
    ROB_DONE = 2'd2
  } rob_state_e;

  // True when slot 'tag' lies strictly after 'ref_tag' and before 'tail' in
  // ring order. A tail index equal to ref_tag can only happen when the ring
  // is full and ref_tag is the head, so the whole ring counts as younger.
  function automatic logic is_younger(input int tag, input int ref_tag,
                                      input int tail, input int depth);
    int d_tag;
    int d_tail;
    d_tag  = (tag - ref_tag) & (depth - 1);
    d_tail = (tail - ref_tag) & (depth - 1);
    if (d_tail == 0) d_tail = depth;
    return (d_tag != 0) && (d_tag < d_tail);
  endfunction

endpackage

// File: rtl/rob_ring_ptr.sv
// Wrapping ring pointer; the MSB is a phase bit that toggles on each wrap.
// Latency: load/increment take effect on the next clock edge.
// Backpressure: none; load has priority over increment.
module rob_ring_ptr #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  // Next pointer: a squash reload wins over a normal advance.
  always_comb begin
    ptr_d = ptr_q;
    if (load_i)     ptr_d = load_val_i;
    else if (inc_i) ptr_d = ptr_q + W'(1);
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: dispatch, out-of-order writeback, in-order commit, partial squash.
// Latency: dispatch/writeback/commit update state next cycle; flush pulse one cycle after a mispredict.
// Backpressure: disp_ready drops when full (registered count) or during a mispredict; commit holds on !cm_ready.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int DEPTH_LOG = 3,
  parameter int DATA_W    = 8,
  parameter int RF_LOG    = 2,
  parameter int PC_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [PC_W-1:0]      disp_pc,
  input  logic                 disp_wen,
  input  logic [RF_LOG-1:0]    disp_rd,
  input  logic                 disp_is_br,
  input  logic                 disp_pred_taken,
  output logic [DEPTH_LOG-1:0] disp_tag,
  input  logic                 wb_valid,
  input  logic [DEPTH_LOG-1:0] wb_tag,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 wb_taken,
  input  logic [PC_W-1:0]      wb_next_pc,
  input  logic [DEPTH_LOG-1:0] lk_tag,
  output logic                 lk_done,
  output logic [DATA_W-1:0]    lk_data,
  output logic                 cm_valid,
  input  logic                 cm_ready,
  output logic [PC_W-1:0]      cm_pc,
  output logic                 cm_wen,
  output logic [RF_LOG-1:0]    cm_rd,
  output logic [DATA_W-1:0]    cm_data,
  output logic                 flush_valid,
  output logic [DEPTH_LOG-1:0] flush_tag,
  output logic [PC_W-1:0]      flush_pc,
  output logic [DEPTH_LOG:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  rob_state_e              state_q [DEPTH];
  rob_state_e              state_d [DEPTH];
  logic [PC_W-1:0]         pc_q    [DEPTH];
  logic                    wen_q   [DEPTH];
  logic [RF_LOG-1:0]       rd_q    [DEPTH];
  logic                    is_br_q [DEPTH];
  logic                    pred_q  [DEPTH];
  logic [DATA_W-1:0]       data_q  [DEPTH];

  logic [DEPTH_LOG:0]      head_ptr, tail_ptr, squash_tail;
  logic [DEPTH_LOG:0]      count_q, count_d;
  logic [DEPTH_LOG-1:0]    head_idx, tail_idx, br_dist;
  logic                    full, wb_hit, mispredict, fire, commit;
  logic                    flush_valid_q;
  logic [DEPTH_LOG-1:0]    flush_tag_q;
  logic [PC_W-1:0]         flush_pc_q;

  assign head_idx = head_ptr[DEPTH_LOG-1:0];
  assign tail_idx = tail_ptr[DEPTH_LOG-1:0];

  // count never exceeds DEPTH, so its MSB alone marks the full condition.
  assign full       = count_q[DEPTH_LOG];
  assign wb_hit     = wb_valid && (state_q[wb_tag] == ROB_BUSY);
  assign mispredict = wb_hit && is_br_q[wb_tag] && (wb_taken != pred_q[wb_tag]);
  assign disp_ready = !full && !mispredict;
  assign fire       = disp_valid && disp_ready;
  assign cm_valid   = (state_q[head_idx] == ROB_DONE);
  assign commit     = cm_valid && cm_ready;
  assign disp_tag   = tail_idx;

  // Rebuild the tail from head so the phase bit stays consistent with it.
  assign br_dist     = wb_tag - head_idx;
  assign squash_tail = head_ptr + (DEPTH_LOG+1)'(br_dist) + (DEPTH_LOG+1)'(1);

  rob_ring_ptr #(.W(DEPTH_LOG+1)) u_head (
    .clk_i      (clk),
    .rst_n_i    (rst),
    .inc_i      (commit),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (head_ptr)
  );

  rob_ring_ptr #(.W(DEPTH_LOG+1)) u_tail (
    .clk_i      (clk),
    .rst_n_i    (rst),
    .inc_i      (fire),
    .load_i     (mispredict),
    .load_val_i (squash_tail),
    .ptr_o      (tail_ptr)
  );

  // Next slot states and occupancy from writeback, squash, dispatch and commit.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) state_d[i] = state_q[i];
    if (wb_hit) state_d[wb_tag] = ROB_DONE;
    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (is_younger(i, int'(wb_tag), int'(tail_idx), DEPTH)) state_d[i] = ROB_IDLE;
      end
    end
    if (fire)   state_d[tail_idx] = ROB_BUSY;
    if (commit) state_d[head_idx] = ROB_IDLE;

    if (mispredict)
      count_d = (DEPTH_LOG+1)'(br_dist) + (DEPTH_LOG+1)'(1) - (DEPTH_LOG+1)'(commit);
    else
      count_d = count_q + (DEPTH_LOG+1)'(fire) - (DEPTH_LOG+1)'(commit);
  end

  // Slot state, occupancy and the registered flush pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ROB_IDLE;
      count_q       <= '0;
      flush_valid_q <= 1'b0;
      flush_tag_q   <= '0;
      flush_pc_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
      count_q       <= count_d;
      flush_valid_q <= mispredict;
      if (mispredict) begin
        flush_tag_q <= wb_tag;
        flush_pc_q  <= wb_next_pc;
      end
    end
  end

  // Entry payload; only the slot state is reset. Resolved direction and
  // target are consumed at writeback time, so an entry keeps just the result.
  always_ff @(posedge clk) begin
    if (fire) begin
      pc_q[tail_idx]    <= disp_pc;
      wen_q[tail_idx]   <= disp_wen;
      rd_q[tail_idx]    <= disp_rd;
      is_br_q[tail_idx] <= disp_is_br;
      pred_q[tail_idx]  <= disp_pred_taken;
    end
    if (wb_hit) data_q[wb_tag] <= wb_data;
  end

  // Lookup with same-cycle writeback bypass.
  always_comb begin
    lk_done = (state_q[lk_tag] == ROB_DONE);
    lk_data = data_q[lk_tag];
    if (wb_valid && (wb_tag == lk_tag)) begin
      lk_done = 1'b1;
      lk_data = wb_data;
    end
  end

  assign cm_pc       = pc_q[head_idx];
  assign cm_wen      = wen_q[head_idx];
  assign cm_rd       = rd_q[head_idx];
  assign cm_data     = data_q[head_idx];
  assign flush_valid = flush_valid_q;
  assign flush_tag   = flush_tag_q;
  assign flush_pc    = flush_pc_q;
  assign count       = count_q;

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: ordering, full/wrap, partial squash, lookup bypass, reset.
// Latency: inputs driven 1ns after posedge, outputs sampled before the next edge.
// Backpressure: cm_ready and disp_valid driven explicitly per step.
module tb_rob_ctrl;
  import rob_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       disp_valid = 1'b0, disp_ready;
  logic [3:0] disp_pc = '0;
  logic       disp_wen = 1'b0;
  logic [1:0] disp_rd = '0;
  logic       disp_is_br = 1'b0, disp_pred_taken = 1'b0;
  logic [2:0] disp_tag;
  logic       wb_valid = 1'b0;
  logic [2:0] wb_tag = '0;
  logic [7:0] wb_data = '0;
  logic       wb_taken = 1'b0;
  logic [3:0] wb_next_pc = '0;
  logic [2:0] lk_tag = '0;
  logic       lk_done;
  logic [7:0] lk_data;
  logic       cm_valid, cm_ready = 1'b0;
  logic [3:0] cm_pc;
  logic       cm_wen;
  logic [1:0] cm_rd;
  logic [7:0] cm_data;
  logic       flush_valid;
  logic [2:0] flush_tag;
  logic [3:0] flush_pc;
  logic [3:0] count;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;

  rob_ctrl dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pc(disp_pc),
    .disp_wen(disp_wen), .disp_rd(disp_rd), .disp_is_br(disp_is_br),
    .disp_pred_taken(disp_pred_taken), .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_taken(wb_taken), .wb_next_pc(wb_next_pc),
    .lk_tag(lk_tag), .lk_done(lk_done), .lk_data(lk_data),
    .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_pc(cm_pc), .cm_wen(cm_wen),
    .cm_rd(cm_rd), .cm_data(cm_data),
    .flush_valid(flush_valid), .flush_tag(flush_tag), .flush_pc(flush_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [3:0] pc, input logic [1:0] rd, input logic is_br,
                          input logic [2:0] exp_tag);
    disp_valid = 1'b1; disp_pc = pc; disp_rd = rd; disp_wen = 1'b1;
    disp_is_br = is_br; disp_pred_taken = 1'b0;
    #1;
    chk("disp_tag", 32'(disp_tag), 32'(exp_tag));
    step();
    disp_valid = 1'b0; disp_is_br = 1'b0;
  endtask

  task automatic writeback(input logic [2:0] tag, input logic [7:0] data,
                           input logic taken, input logic [3:0] npc);
    wb_valid = 1'b1; wb_tag = tag; wb_data = data; wb_taken = taken; wb_next_pc = npc;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_cm_valid", 32'(cm_valid), 0);
    chk("rst_disp_ready", 32'(disp_ready), 1);
    chk("rst_lk_done", 32'(lk_done), 0);
    chk("rst_flush_valid", 32'(flush_valid), 0);
    chk("rst_flush_tag", 32'(flush_tag), 0);
    chk("rst_flush_pc", 32'(flush_pc), 0);
    rst = 1'b1;

    // In-order commit with out-of-order writeback
    dispatch(4'd1, 2'd1, 1'b0, 3'd0);
    dispatch(4'd2, 2'd2, 1'b0, 3'd1);
    dispatch(4'd3, 2'd3, 1'b0, 3'd2);
    chk("t1_count3", 32'(count), 3);
    writeback(3'd2, 8'h22, 1'b0, 4'd0);
    chk("t1_cm_valid_after_wb2", 32'(cm_valid), 0);
    writeback(3'd0, 8'h10, 1'b0, 4'd0);
    chk("t1_cm_valid_after_wb0", 32'(cm_valid), 1);
    chk("t1_cm_data0", 32'(cm_data), 32'h10);
    writeback(3'd1, 8'h11, 1'b0, 4'd0);
    cm_ready = 1'b1;
    chk("t1_cm_pc0", 32'(cm_pc), 1);
    chk("t1_cm_rd0", 32'(cm_rd), 1);
    step();
    chk("t1_cm_pc1", 32'(cm_pc), 2);
    chk("t1_cm_data1", 32'(cm_data), 32'h11);
    step();
    chk("t1_cm_pc2", 32'(cm_pc), 3);
    chk("t1_cm_data2", 32'(cm_data), 32'h22);
    chk("t1_cm_wen2", 32'(cm_wen), 1);
    step();
    cm_ready = 1'b0;
    chk("t1_cm_valid_empty", 32'(cm_valid), 0);
    chk("t1_count0", 32'(count), 0);

    // Full buffer and wrap-around
    do_reset();
    for (int i = 0; i < 8; i++) dispatch(4'(i), 2'(i), 1'b0, 3'(i));
    chk("t2_count8", 32'(count), 8);
    chk("t2_full_ready", 32'(disp_ready), 0);
    chk("t2_tail_ptr8", 32'(dut.tail_ptr), 8);
    writeback(3'd0, 8'hA0, 1'b0, 4'd0);
    cm_ready = 1'b1; disp_valid = 1'b1; disp_pc = 4'd9; disp_rd = 2'd1;
    #1;
    chk("t2_ready_blocked_during_commit", 32'(disp_ready), 0);
    step();
    cm_ready = 1'b0;
    chk("t2_count7", 32'(count), 7);
    chk("t2_ready_after_commit", 32'(disp_ready), 1);
    chk("t2_tag_wrap", 32'(disp_tag), 0);
    step();
    disp_valid = 1'b0;
    chk("t2_count8_again", 32'(count), 8);
    chk("t2_tail_phase", 32'(dut.tail_ptr), 9);
    chk("t2_head_ptr", 32'(dut.head_ptr), 1);

    // Partial squash on a mispredicted branch
    do_reset();
    for (int i = 0; i < 5; i++) dispatch(4'(i), 2'(i), (i == 1), 3'(i));
    wb_valid = 1'b1; wb_tag = 3'd1; wb_data = 8'h77; wb_taken = 1'b1; wb_next_pc = 4'd9;
    #1;
    chk("t3_ready_on_mispredict", 32'(disp_ready), 0);
    step();
    wb_valid = 1'b0;
    chk("t3_flush_valid", 32'(flush_valid), 1);
    chk("t3_flush_tag", 32'(flush_tag), 1);
    chk("t3_flush_pc", 32'(flush_pc), 9);
    chk("t3_count2", 32'(count), 2);
    chk("t3_state2_idle", 32'(dut.state_q[2]), 32'(ROB_IDLE));
    chk("t3_state3_idle", 32'(dut.state_q[3]), 32'(ROB_IDLE));
    chk("t3_state4_idle", 32'(dut.state_q[4]), 32'(ROB_IDLE));
    chk("t3_state0_busy", 32'(dut.state_q[0]), 32'(ROB_BUSY));
    chk("t3_state1_done", 32'(dut.state_q[1]), 32'(ROB_DONE));
    lk_tag = 3'd1;
    #1;
    chk("t3_lk_branch_done", 32'(lk_done), 1);
    chk("t3_lk_branch_data", 32'(lk_data), 32'h77);
    dispatch(4'd5, 2'd2, 1'b0, 3'd2);
    chk("t3_flush_drop", 32'(flush_valid), 0);
    chk("t3_count3", 32'(count), 3);

    // Writeback to an IDLE tag is ignored
    writeback(3'd3, 8'h33, 1'b0, 4'd0);
    lk_tag = 3'd3;
    #1;
    chk("t4_lk_idle", 32'(lk_done), 0);
    chk("t4_count", 32'(count), 3);
    chk("t4_state3_idle", 32'(dut.state_q[3]), 32'(ROB_IDLE));

    // Lookup bypass from same-cycle writeback
    dispatch(4'd6, 2'd3, 1'b0, 3'd3);
    wb_valid = 1'b1; wb_tag = 3'd3; wb_data = 8'h5A; wb_taken = 1'b0; lk_tag = 3'd3;
    #1;
    chk("t5_bypass_done", 32'(lk_done), 1);
    chk("t5_bypass_data", 32'(lk_data), 32'h5A);
    step();
    wb_valid = 1'b0;
    #1;
    chk("t5_stored_done", 32'(lk_done), 1);
    chk("t5_stored_data", 32'(lk_data), 32'h5A);
    lk_tag = 3'd2;
    #1;
    chk("t5_busy_not_done", 32'(lk_done), 0);

    // Reset with five entries occupied
    dispatch(4'd7, 2'd0, 1'b0, 3'd4);
    chk("t6_count5", 32'(count), 5);
    rst = 1'b0;
    step();
    chk("t6_count0", 32'(count), 0);
    chk("t6_cm_valid", 32'(cm_valid), 0);
    chk("t6_flush_valid", 32'(flush_valid), 0);
    chk("t6_flush_tag", 32'(flush_tag), 0);
    chk("t6_disp_ready", 32'(disp_ready), 1);
    rst = 1'b1;
    step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
